sys_input_skewer: RTL and testbench
===================================

Name: sys_input_skewer

Overview:
Upstream feeder for the systolic MAC grid. Accepts one activation vector per cycle (one DATA_W element per array row) over a valid/ready handshake. Delays row k by k extra cycles to form the diagonal wavefront the MAC rows expect on their data inputs. Flushes the skew pipeline after each tile and flags tile completion.

Parameters:
N_ROWS, 4, number of array rows / lanes (>=1)
DATA_W, 16, element width; matches MAC data input width

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_valid  in  1  upstream vector valid
o_ready  out  1  skewer can accept a vector this cycle
i_data  in  N_ROWS*DATA_W  vector; lane k = bits [k*DATA_W +: DATA_W]
i_last  in  1  qualifies i_valid: final vector of current tile
o_data  out  N_ROWS*DATA_W  skewed lanes to MAC row data inputs
o_valid  out  N_ROWS  per-lane element valid
o_tile_done  out  1  one-cycle pulse, last element of tile leaving lane N_ROWS-1
o_busy  out  1  tile in progress (FEED or DRAIN)

Behaviour:
- Reset (async assert, sync-released use): all lane pipeline registers, o_data, o_valid = 0; o_tile_done = 0; state = IDLE; o_busy = 0; drain counter = 0. o_ready = 0 while i_rstn low.
- Accept = i_valid & o_ready, sampled on rising edge.
- Lane k is a (k+1)-deep register chain, shifting every cycle unconditionally; no downstream backpressure.
- Insert value per cycle: i_data lane k with valid 1 on accept; otherwise 0 with valid 0 (bubble).
- Latency: element accepted at edge E appears on lane k after edge E+k. Lane 0 has 1-register latency; lane k has k+1.
- o_ready is combinational from state: 1 in IDLE and FEED, 0 in DRAIN.
- FSM:
  - IDLE: o_busy = 0. Accept & !i_last -> FEED. Accept & i_last -> DRAIN, or straight to IDLE with tile_done if N_ROWS = 1.
  - FEED: o_busy = 1. Accept & i_last -> DRAIN. i_valid low keeps FEED and inserts a bubble.
  - DRAIN: o_busy = 1. Counter loads N_ROWS-1 on entry and decrements each cycle. i_valid ignored; bubbles inserted. Counter reaching 1 -> IDLE at the next edge, o_tile_done registered high for exactly that one cycle.
- o_tile_done coincides with o_valid[N_ROWS-1] for the last vector. At that cycle o_ready is already 1 again, so a new tile may be accepted in the same cycle with no overlap hazard.
- i_last without i_valid: ignored.
- Widths: data passes unmodified; no arithmetic or sign handling.
- Reset mid-tile (any state): pipeline cleared immediately; no o_tile_done; IDLE after release.

Optional Feature:
SKEW_VEC_COUNT_EN
- Defined: adds output o_vec_count [15:0] counting vectors accepted in the current tile, including the last. Zero on reset. Cleared to 0 on the cycle after o_tile_done. Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. N_ROWS=4. Reset, then a single vector lanes {0:1, 1:2, 2:3, 3:4} with i_last, accepted at edge E -> lane k = k+1 valid for one cycle after edge E+k; o_ready = 0 for 3 cycles; o_tile_done high with lane 3 = 4; then IDLE.
2. Back-to-back vectors V0={1,1,1,1}, V1={2,2,2,2}, V2={3,3,3,3} (last), accepted at E, E+1, E+2 -> lane k shows 1, 2, 3 after edges E+k, E+k+1, E+k+2; diagonal wavefront; tile_done after E+5.
3. Bubble: V0 at E, i_valid=0 at E+1, V1 (last) at E+2 -> each lane shows V0, then 0 with valid 0, then V1, shifted by k.
4. i_valid=1 held with data 16'hDEAD during DRAIN -> not accepted; no lane ever shows 16'hDEAD; o_ready stays 0 throughout DRAIN.
5. Assert i_rstn low during DRAIN (lane 3 not yet output) -> o_data and o_valid = 0 immediately; no tile_done; o_ready = 1 after release.
6. With SKEW_VEC_COUNT_EN defined: 3-vector tile -> o_vec_count steps 1, 2, 3, holds 3 through DRAIN, returns to 0 the cycle after o_tile_done.

Source files
------------

// File: rtl/sys_input_skewer_if.sv
// rtl/sys_input_skewer_if.sv - vector stream and skewed-lane bundle for the systolic input skewer (SKEW_VEC_COUNT_EN adds o_vec_count)
interface sys_input_skewer_if #(
  parameter int N_ROWS = 4,
  parameter int DATA_W = 16
);
  logic                     i_valid;
  logic                     o_ready;
  logic [N_ROWS*DATA_W-1:0] i_data;
  logic                     i_last;
  logic [N_ROWS*DATA_W-1:0] o_data;
  logic [N_ROWS-1:0]        o_valid;
  logic                     o_tile_done;
  logic                     o_busy;
`ifdef SKEW_VEC_COUNT_EN
  logic [15:0]              o_vec_count;

  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_data, o_valid, o_tile_done, o_busy, o_vec_count
  );
  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_data, o_valid, o_tile_done, o_busy, o_vec_count
  );
`else
  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_data, o_valid, o_tile_done, o_busy
  );
  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_data, o_valid, o_tile_done, o_busy
  );
`endif
endinterface

// File: rtl/sys_input_skewer.sv
// rtl/sys_input_skewer.sv - diagonal skew of activation vectors into the MAC grid (optional SKEW_VEC_COUNT_EN vector counter)
module sys_input_skewer #(
  parameter int N_ROWS = 4,
  parameter int DATA_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  sys_input_skewer_if.slave  sk
);

  localparam int CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              accept;

  wire  [DATA_W-1:0] tail_data [N_ROWS];
  wire  [N_ROWS-1:0] tail_vld;

  // Ready is withheld only while the skew pipeline drains; forced low in reset.
  assign sk.o_ready = i_rstn & (state_q != S_DRAIN);
  assign accept     = sk.i_valid & sk.o_ready;
  assign sk.o_busy  = (state_q != S_IDLE);
  assign sk.o_tile_done = done_q;
  assign sk.o_valid = tail_vld;

  // Tile sequencing: feed vectors until i_last, then drain N_ROWS-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_FEED: begin
        if (accept) begin
          if (sk.i_last) begin
            if (N_ROWS == 1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DRAIN;
              cnt_d   = CNT_W'(N_ROWS - 1);
            end
          end else begin
            state_d = S_FEED;
          end
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, drain counter and tile-done pulse registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < N_ROWS; k++) begin : g_lane
    localparam int DEPTH = k + 1;
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DATA_W-1:0] dat_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;

    // Lane k shift chain: insert the accepted element or a bubble every cycle.
    always_comb begin
      vld_d = '0;
      for (int s = 0; s < DEPTH; s++) dat_d[s] = '0;
      dat_d[0] = accept ? sk.i_data[k*DATA_W +: DATA_W] : '0;
      vld_d[0] = accept;
      for (int s = 1; s < DEPTH; s++) begin
        dat_d[s] = dat_q[s-1];
        vld_d[s] = vld_q[s-1];
      end
    end

    // Lane k registers; cleared at once by reset so nothing half-tiled leaks out.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int s = 0; s < DEPTH; s++) dat_q[s] <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign tail_data[k] = dat_q[DEPTH-1];
    assign tail_vld[k]  = vld_q[DEPTH-1];
  end

  // Pack the lane tails onto the flat output bus.
  always_comb begin
    sk.o_data = '0;
    for (int k = 0; k < N_ROWS; k++) sk.o_data[k*DATA_W +: DATA_W] = tail_data[k];
  end

`ifdef SKEW_VEC_COUNT_EN
  logic [15:0] vc_q, vc_d;

  // Vectors accepted in the current tile; restarts the cycle after tile done.
  always_comb begin
    vc_d = vc_q;
    if (done_q) begin
      vc_d = accept ? 16'd1 : 16'd0;
    end else if (accept && (vc_q != 16'hFFFF)) begin
      vc_d = vc_q + 16'd1;
    end
  end

  // Vector counter register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) vc_q <= '0;
    else         vc_q <= vc_d;
  end

  assign sk.o_vec_count = vc_q;
`endif

endmodule

// File: tb/tb_sys_input_skewer.sv
// tb/tb_sys_input_skewer.sv - randomized self-checking bench for sys_input_skewer
module tb_sys_input_skewer;

  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int HMAX = 4096;

  logic clk;
  logic rstn;

  sys_input_skewer_if #(.N_ROWS(NR), .DATA_W(DW)) bus ();

  sys_input_skewer #(.N_ROWS(NR), .DATA_W(DW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .sk     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // History of what entered the skewer at each edge since the last reset.
  logic [NR*DW-1:0] hist_d [HMAX];
  logic             hist_v [HMAX];
  int               t;
  logic             has_last;
  int               last_edge;
  logic             tile_open;
  int               vc_model;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, t);
    end
  endtask

  function automatic logic draining();
    return has_last && (t >= last_edge) && (t < last_edge + NR - 1);
  endfunction

  function automatic logic done_now();
    return has_last && (t == last_edge + NR - 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < HMAX; i++) begin
      hist_d[i] = '0;
      hist_v[i] = 1'b0;
    end
    has_last  = 1'b0;
    last_edge = 0;
    tile_open = 1'b0;
    vc_model  = 0;
  endtask

  task automatic check_outputs();
    logic [NR*DW-1:0] ed;
    logic [NR-1:0]    ev;
    ed = '0;
    ev = '0;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = t - k;
      if (idx >= 1 && hist_v[idx]) begin
        ed[k*DW +: DW] = hist_d[idx][k*DW +: DW];
        ev[k] = 1'b1;
      end
    end
    check("o_data", bus.o_data, ed);
    check("o_valid", 64'(bus.o_valid), 64'(ev));
    check("o_ready", 64'(bus.o_ready), 64'(!draining()));
    check("o_tile_done", 64'(bus.o_tile_done), 64'(done_now()));
    check("o_busy", 64'(bus.o_busy), 64'(tile_open || draining()));
`ifdef SKEW_VEC_COUNT_EN
    check("o_vec_count", 64'(bus.o_vec_count), 64'(vc_model));
`endif
  endtask

  // Drive one cycle of input at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [NR*DW-1:0] d, input logic l);
    logic acc;
    logic pdone;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
    acc   = v && !draining();
    pdone = done_now();
    @(posedge clk);
    t++;
    hist_v[t] = acc;
    hist_d[t] = acc ? d : '0;
    if (pdone) vc_model = acc ? 1 : 0;
    else if (acc && vc_model != 16'hFFFF) vc_model++;
    if (acc && l) begin
      has_last  = 1'b1;
      last_edge = t;
      tile_open = 1'b0;
    end else if (acc) begin
      tile_open = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, {NR*DW{1'b0}}, 1'b0);
  endtask

  // Asynchronous reset mid-flight: outputs must clear without waiting for a clock.
  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_o_data", bus.o_data, 64'h0);
    check("rst_o_valid", 64'(bus.o_valid), 64'h0);
    check("rst_o_ready", 64'(bus.o_ready), 64'h0);
    check("rst_tile_done", 64'(bus.o_tile_done), 64'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_tile_done", 64'(bus.o_tile_done), 64'h0);
    check("rst_hold_o_valid", 64'(bus.o_valid), 64'h0);
    rstn = 1'b1;
    model_clear();
    #1;
    check("post_rst_ready", 64'(bus.o_ready), 64'h1);
    check("post_rst_busy", 64'(bus.o_busy), 64'h0);
  endtask

  initial begin
    logic [NR*DW-1:0] dead;
    dead = {NR{16'hDEAD}};
    t = 0;
    model_clear();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    rstn = 1'b0;
    #1;
    check("reset_ready", 64'(bus.o_ready), 64'h0);
    check("reset_valid", 64'(bus.o_valid), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_outputs();

    // Single-vector tile, lanes 1..4.
    step(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
    idle(5);

    // Back-to-back three-vector tile.
    step(1'b1, {4{16'd1}}, 1'b0);
    step(1'b1, {4{16'd2}}, 1'b0);
    step(1'b1, {4{16'd3}}, 1'b1);
    idle(5);

    // Bubble between two vectors.
    step(1'b1, {4{16'h00A0}}, 1'b0);
    step(1'b0, {4{16'h5555}}, 1'b1);
    step(1'b1, {4{16'h00B0}}, 1'b1);
    idle(5);

    // i_valid held high with DEAD data through the drain.
    step(1'b1, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b1);
    for (int i = 0; i < NR - 1; i++) begin
      step(1'b1, dead, 1'b0);
      for (int k = 0; k < NR; k++)
        check("no_dead", 64'(bus.o_valid[k] && bus.o_data[k*DW +: DW] == 16'hDEAD), 64'h0);
    end
    idle(4);

    // Reset while draining, before lane 3 has produced the last vector.
    step(1'b1, {4{16'h0101}}, 1'b0);
    step(1'b1, {4{16'h0202}}, 1'b1);
    step(1'b0, {NR*DW{1'b0}}, 1'b0);
    do_reset();
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic v, l;
      logic [NR*DW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      d = {$urandom, $urandom};
      step(v, d, l);
      if (i == 300) begin
        do_reset();
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
